data_mem_access_unit: RTL

//  Load/store access unit between the multicycle control FSM/datapath and data memory.
//  On a start pulse it latches the ALU address, store data, BE and funct3, then shifts
//  the data and byte enables into memory byte lanes and runs a req/ack handshake.
//  For loads it extracts, sign- or zero-extends and registers the data for writeback.

---
 rtl/data_mem_access_unit_pkg.sv | 37 +++
 rtl/data_mem_access_unit_align.sv | 36 +++
 rtl/data_mem_access_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_access_unit_pkg.sv
// Shared constants for the load/store access path: FSM encoding, size codes
// and load/store funct3 values. The control FSM uses the same definitions.
package data_mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  function automatic logic be_legal(input logic [3:0] be);
    return (be == BE_BYTE) || (be == BE_HALF) || (be == BE_WORD);
  endfunction

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == SB) || (f3 == SH) || (f3 == SW);
  endfunction

endpackage

// File: rtl/data_mem_access_unit_align.sv
// Byte-lane alignment between the core and a word-wide memory.
// Store path shifts enables/data into lanes; load path shifts down and extends.
module mem_lane_align
  import data_mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        off,
  input  logic [3:0]        be_in,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be_out,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] load_out
);

  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] rd;

  // Lane shifting; store bytes outside the access size are forced to zero
  always_comb begin
    wmask    = {{8{be_in[3]}}, {8{be_in[2]}}, {8{be_in[1]}}, {8{be_in[0]}}};
    be_out   = be_in << off;
    dout     = (wdata & wmask) << {off, 3'b000};
    rd       = rdata >> {off, 3'b000};
    case (funct3)
      LB:      load_out = {{(DATA_W-8){rd[7]}}, rd[7:0]};
      LH:      load_out = {{(DATA_W-16){rd[15]}}, rd[15:0]};
      LBU:     load_out = {{(DATA_W-8){1'b0}}, rd[7:0]};
      LHU:     load_out = {{(DATA_W-16){1'b0}}, rd[15:0]};
      default: load_out = rd;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// Load/store access unit: latches a request on start, validates it, runs the
// memory handshake with a timeout, and registers extended load data.
//
// Memory handshake: D_MEM_REQ rises on entry to REQ and stays high, with WEN,
// ADDR, BE and DOUT stable, until the cycle D_MEM_ACK is sampled high or the
// wait counter aborts. ACK is only looked at while in REQ; D_MEM_DI is taken
// in the ack cycle.
module data_mem_access_unit
  import data_mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [3:0]        BE,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              D_MEM_REQ,
  output logic              D_MEM_WEN,
  output logic [ADDR_W-1:0] D_MEM_ADDR,
  output logic [3:0]        D_MEM_BE,
  output logic [DATA_W-1:0] D_MEM_DOUT,
  input  logic [DATA_W-1:0] D_MEM_DI,
  input  logic              D_MEM_ACK,
  output logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              req_q, req_d, wen_q, wen_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [3:0]        mbe_q, mbe_d;
  logic [DATA_W-1:0] mdout_q, mdout_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic              access_bad, timeout_hit;
  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_dout, lane_load;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .off      (addr_q[1:0]),
    .be_in    (be_q),
    .wdata    (wdata_q),
    .funct3   (funct3_q),
    .rdata    (D_MEM_DI),
    .be_out   (lane_be),
    .dout     (lane_dout),
    .load_out (lane_load)
  );

  assign timeout_hit = (cnt_q == TO_LAST);

  // Legality of the latched access: direction, size code, alignment, funct3
  always_comb begin
    access_bad = 1'b0;
    if (rd_q == wr_q) access_bad = 1'b1;
    if (!be_legal(be_q)) access_bad = 1'b1;
    if ((be_q == BE_HALF) && addr_q[0]) access_bad = 1'b1;
    if ((be_q == BE_WORD) && (addr_q[1:0] != 2'b00)) access_bad = 1'b1;
    if (rd_q && !wr_q && !load_f3_legal(funct3_q)) access_bad = 1'b1;
    if (wr_q && !rd_q && !store_f3_legal(funct3_q)) access_bad = 1'b1;
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RSTn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHECK;
      ST_CHECK: begin
        cnt_d   = 8'd0;
        state_d = access_bad ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (D_MEM_ACK || timeout_hit) state_d = ST_DONE;
        else                          cnt_d   = cnt_q + 8'd1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    req_d       = (state_d == ST_REQ);
    wen_d       = req_d & wr_q;
    maddr_d     = req_d ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mbe_d       = req_d ? lane_be : 4'b0000;
    mdout_d     = req_d ? lane_dout : '0;
    busy_d      = (state_d == ST_CHECK) || (state_d == ST_REQ);
    done_d      = (state_d == ST_DONE);
    err_d       = ((state_q == ST_CHECK) && access_bad) ||
                  ((state_q == ST_REQ) && !D_MEM_ACK && timeout_hit);
    load_data_d = ((state_q == ST_REQ) && D_MEM_ACK && rd_q) ? lane_load : load_data_q;
  end

  // Request capture on an accepted start
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    if ((state_q == ST_IDLE) && start) begin
      addr_d   = addr;
      wdata_d  = wdata;
      be_d     = BE;
      funct3_d = funct3;
      rd_d     = MemRead;
      wr_d     = MemWrite;
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'b0000;
      funct3_q    <= 3'b000;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      wen_q       <= 1'b0;
      maddr_q     <= '0;
      mbe_q       <= 4'b0000;
      mdout_q     <= '0;
      load_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      wen_q       <= wen_d;
      maddr_q     <= maddr_d;
      mbe_q       <= mbe_d;
      mdout_q     <= mdout_d;
      load_data_q <= load_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign D_MEM_REQ  = req_q;
  assign D_MEM_WEN  = wen_q;
  assign D_MEM_ADDR = maddr_q;
  assign D_MEM_BE   = mbe_q;
  assign D_MEM_DOUT = mdout_q;
  assign load_data  = load_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
